// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, PC command encodings, fetch FSM states,
// width defaults and the instruction decode helper used by the fetch sequencer.
package cpu_pkg;

  localparam int AW_DEF      = 12;
  localparam int DW_DEF      = 16;
  localparam int PC_LAT_DEF  = 2;
  localparam int TIMEOUT_DEF = 15;

  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  // {loadPC, incPC}
  localparam logic [1:0] PC_CLR  = 2'b00;
  localparam logic [1:0] PC_LOAD = 2'b10;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_HOLD = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DECODE = 3'd3,
    ST_ISSUE  = 3'd4,
    ST_UPDATE = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef struct packed {
    state_e     nxt;
    logic [1:0] cmd;
    logic       load;
  } dec_t;

  // Control-flow ops resolve here; everything else is handed to execute.
  function automatic dec_t decode_op(input logic [3:0] opcode, input logic zero);
    dec_t d;
    d.nxt  = ST_ISSUE;
    d.cmd  = PC_HOLD;
    d.load = 1'b0;
    case (opcode)
      OP_JMP: begin
        d.nxt  = ST_UPDATE;
        d.cmd  = PC_LOAD;
        d.load = 1'b1;
      end
      OP_JZ: begin
        d.nxt  = ST_UPDATE;
        d.cmd  = zero ? PC_LOAD : PC_INC;
        d.load = zero;
      end
      OP_HLT: d.nxt = ST_HALT;
      default: d.nxt = ST_ISSUE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing FSM driving the PC control pins.
// Optional fetch timeout enabled by defining FETCH_SEQ_TIMEOUT_EN.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int PC_LAT = PC_LAT_DEF
`ifdef FETCH_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_addr,
  output logic          loadPC,
  output logic          incPC,
  output logic [AW-1:0] address,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  input  logic          zero_flag,
  output logic [DW-1:0] ir,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic          halted,
  output logic          fetch_err
);

  localparam int SCW = (PC_LAT > 1) ? $clog2(PC_LAT) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(PC_LAT - 1);

  state_e        r_state;
  logic [1:0]    r_pc_cmd;
  logic [AW-1:0] r_address;
  logic          r_mem_req;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_ir;
  logic          r_ir_valid;
  logic          r_halted;
  logic [SCW-1:0] r_settle_cnt;
  dec_t          w_dec;

`ifdef FETCH_SEQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_wait_cnt;
  logic       r_fetch_err;
  assign fetch_err = r_fetch_err;
`else
  assign fetch_err = 1'b0;
`endif

  assign w_dec = decode_op(r_ir[DW-1 -: 4], zero_flag);

  // Outputs are registered one cycle ahead of the state that owns them,
  // so the CLR/LOAD/INC command is visible while in UPDATE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_INIT;
      r_pc_cmd     <= PC_HOLD;
      r_address    <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_ir         <= '0;
      r_ir_valid   <= 1'b0;
      r_halted     <= 1'b0;
      r_settle_cnt <= '0;
`ifdef FETCH_SEQ_TIMEOUT_EN
      r_wait_cnt   <= 8'd0;
      r_fetch_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_INIT: begin
          r_pc_cmd <= PC_CLR;
          r_state  <= ST_UPDATE;
        end
        ST_UPDATE: begin
          r_pc_cmd     <= PC_HOLD;
          r_settle_cnt <= '0;
          r_state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // pc_addr is only trustworthy once the PC pipeline has drained.
          if (r_settle_cnt == SETTLE_LAST) begin
            r_state    <= ST_FETCH;
            r_mem_req  <= 1'b1;
            r_mem_addr <= pc_addr;
`ifdef FETCH_SEQ_TIMEOUT_EN
            r_wait_cnt <= 8'd0;
`endif
          end else begin
            r_settle_cnt <= r_settle_cnt + SCW'(1);
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            r_ir      <= mem_rdata;
            r_mem_req <= 1'b0;
            r_state   <= ST_DECODE;
          end
`ifdef FETCH_SEQ_TIMEOUT_EN
          else if (r_wait_cnt == TIMEOUT_LAST) begin
            r_fetch_err <= 1'b1;
            r_mem_req   <= 1'b0;
            r_halted    <= 1'b1;
            r_state     <= ST_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
`endif
        end
        ST_DECODE: begin
          r_pc_cmd <= w_dec.cmd;
          if (w_dec.load) begin
            r_address <= r_ir[AW-1:0];
          end
          r_ir_valid <= (w_dec.nxt == ST_ISSUE);
          r_halted   <= (w_dec.nxt == ST_HALT);
          r_state    <= w_dec.nxt;
        end
        ST_ISSUE: begin
          if (r_ir_valid && ir_ready) begin
            r_ir_valid <= 1'b0;
            r_pc_cmd   <= PC_INC;
            r_state    <= ST_UPDATE;
          end
        end
        ST_HALT: begin
          r_pc_cmd  <= PC_HOLD;
          r_mem_req <= 1'b0;
          r_halted  <= 1'b1;
        end
        default: begin
          r_pc_cmd <= PC_HOLD;
          r_state  <= ST_INIT;
        end
      endcase
    end
  end

  assign loadPC   = r_pc_cmd[1];
  assign incPC    = r_pc_cmd[0];
  assign address  = r_address;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign ir       = r_ir;
  assign ir_valid = r_ir_valid;
  assign halted   = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a behavioural 2-stage PC and
// zero-latency memory; timeout checks run when FETCH_SEQ_TIMEOUT_EN is defined.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] pc_addr;
  logic        loadPC, incPC;
  logic [11:0] address;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        zero_flag;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready = 1'b1;
  logic        halted;
  logic        fetch_err;

  logic        ack_en = 1'b1;
  logic [15:0] mem [0:4095];
  logic [11:0] pc_temp = 12'h5A5;
  logic [11:0] pc_exec = 12'h5A5;

  logic [11:0] q_fetch [$];
  logic [15:0] q_issue [$];
  int n_cmp = 0;
  int n_err = 0;
  int fetch_count = 0;
  int stall_n = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .loadPC(loadPC), .incPC(incPC),
    .address(address), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .zero_flag(zero_flag), .ir(ir), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Program counter: command sampled into temp, temp copied to execadd.
  always @(posedge clk) begin
    case ({loadPC, incPC})
      2'b00:   pc_temp <= 12'h000;
      2'b10:   pc_temp <= address;
      2'b01:   pc_temp <= pc_temp + 12'h001;
      default: pc_temp <= pc_temp;
    endcase
    pc_exec <= pc_temp;
  end
  assign pc_addr   = pc_exec;
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req & ack_en;
  assign zero_flag = (mem_addr == 12'hABC);

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a fetch or issue handshake is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req && mem_ack) begin
        fetch_count++;
        if (q_fetch.size() == 0) check("fetch_unexpected", {4'h0, mem_addr}, 16'hFFFF);
        else check("fetch_addr", {4'h0, mem_addr}, {4'h0, q_fetch.pop_front()});
      end
      if (ir_valid && ir_ready) begin
        if (q_issue.size() == 0) check("issue_unexpected", ir, 16'hDEAD);
        else check("issue_ir", ir, q_issue.pop_front());
      end
    end
  end

  // Execute back-pressure: stall the op fetched from 0x051 for 5 cycles.
  always @(posedge clk) begin
    #1;
    if (rst_n && ir_valid && mem_addr == 12'h051 && stall_n < 5) begin
      ir_ready = 1'b0;
      stall_n++;
      check("stall_ir", ir, 16'h2345);
      check("stall_hold", {14'd0, loadPC, incPC}, 16'h0003);
    end else begin
      ir_ready = 1'b1;
    end
  end

  task automatic wait_halted(input int budget, input string nm);
    int i = 0;
    while (!halted && i < budget) begin @(negedge clk); i++; end
    check(nm, {15'd0, halted}, 16'h0001);
  endtask

  task automatic wait_req(input int budget, input string nm);
    int i = 0;
    while (!mem_req && i < budget) begin @(negedge clk); i++; end
    check(nm, {15'd0, mem_req}, 16'h0001);
  endtask

  initial begin
    int i;
    for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
    mem[12'h000] = 16'h1234;
    mem[12'h001] = 16'h8ABC;
    mem[12'hABC] = 16'h9050;
    mem[12'h050] = 16'h9123;
    mem[12'h051] = 16'h2345;
    mem[12'h052] = 16'h8FFF;
    mem[12'hFFF] = 16'h1111;
    q_fetch = '{12'h000, 12'h001, 12'hABC, 12'h050, 12'h051, 12'h052, 12'hFFF, 12'h000};
    q_issue = '{16'h1234, 16'h2345, 16'h1111};

    repeat (3) @(negedge clk);
    check("rst_pccmd", {14'd0, loadPC, incPC}, 16'h0003);
    check("rst_address", {4'h0, address}, 16'h0000);
    check("rst_mem_req", {15'd0, mem_req}, 16'h0000);
    check("rst_mem_addr", {4'h0, mem_addr}, 16'h0000);
    check("rst_ir", ir, 16'h0000);
    check("rst_flags", {13'd0, ir_valid, halted, fetch_err}, 16'h0000);

    rst_n = 1'b1;
    @(negedge clk);
    check("init_clr", {14'd0, loadPC, incPC}, 16'h0000);
    @(negedge clk);
    check("settle_hold", {14'd0, loadPC, incPC}, 16'h0003);

    i = 0;
    while (fetch_count < 2 && i < 100) begin @(negedge clk); i++; end
    check("reach_fetch2", {15'd0, fetch_count >= 2}, 16'h0001);
    mem[12'h000] = 16'hF000;

    wait_halted(400, "halt_reached");
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check("halt_hold", {12'd0, halted, loadPC, incPC, mem_req}, 16'h000E);
    end
    check("fetch_q_empty", 16'(q_fetch.size()), 16'h0000);
    check("issue_q_empty", 16'(q_issue.size()), 16'h0000);

    // Restart, then reset while stuck in FETCH.
    ack_en = 1'b0;
    mem[12'h000] = 16'h1234;
    mem[12'h001] = 16'hF001;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_halted", {15'd0, halted}, 16'h0000);
    rst_n = 1'b1;
    wait_req(20, "restart_req");
    check("restart_addr", {4'h0, mem_addr}, 16'h0000);
    repeat (3) @(negedge clk);
    check("stuck_req", {15'd0, mem_req}, 16'h0001);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", {15'd0, mem_req}, 16'h0000);
    check("midrst_pccmd", {14'd0, loadPC, incPC}, 16'h0003);
    check("midrst_valid", {15'd0, ir_valid}, 16'h0000);
    @(negedge clk);
    q_fetch = '{12'h000, 12'h001};
    q_issue = '{16'h1234};
    ack_en = 1'b1;
    rst_n = 1'b1;
    wait_halted(100, "halt2_reached");
    repeat (2) @(negedge clk);
    check("fetch_q_empty2", 16'(q_fetch.size()), 16'h0000);
    check("issue_q_empty2", 16'(q_issue.size()), 16'h0000);

`ifdef FETCH_SEQ_TIMEOUT_EN
    ack_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_req(20, "to_req");
    i = 0;
    while (mem_req && i < 40) begin i++; @(negedge clk); end
    check("to_cycles", 16'(i), 16'd15);
    check("to_err", {14'd0, fetch_err, halted}, 16'h0003);
    repeat (5) @(negedge clk);
    check("to_sticky", {13'd0, fetch_err, halted, mem_req}, 16'h0006);
`else
    check("no_fetch_err", {15'd0, fetch_err}, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction fetch/sequencing stage that drives the 12-bit program counter's control pins (load/increment/hold/clear) and consumes its `execadd` output as the fetch address.
- Reads 16-bit instruction words from memory over a req/ack handshake and latches them into an instruction register.
- Resolves JMP/JZ/HLT locally. Passes all other instructions downstream to execute over a valid/ready handshake.

Parameters:
- AW, 12, address width; matches PC width.
- DW, 16, instruction width.
- PC_LAT, 2, cycles from PC command to updated execadd (PC registers temp, then execadd).
- TIMEOUT, 15, max cycles waiting on mem_ack (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_addr  in  AW  current PC value (PC execadd).
- loadPC  out  1  PC load control.
- incPC  out  1  PC increment control.
- address  out  AW  jump target presented to PC.
- mem_req  out  1  fetch request; held until ack.
- mem_addr  out  AW  fetch address.
- mem_rdata  in  DW  instruction word; valid with mem_ack.
- mem_ack  in  1  one-cycle read completion.
- zero_flag  in  1  ALU zero flag, sampled in DECODE.
- ir  out  DW  instruction register.
- ir_valid  out  1  ir holds an instruction for execute.
- ir_ready  in  1  execute accepts ir.
- halted  out  1  HLT reached.
- fetch_err  out  1  timeout error (optional feature only; tied 0 otherwise).

Behaviour:
- PC command encoding (loadPC,incPC):
  - CLR=00 (PC clears to 0)
  - LOAD=10
  - INC=01
  - HOLD=11
- Default output in every state not listed below is HOLD.
- Instruction format: opcode=ir[15:12], operand=ir[11:0].
  - JMP=4'h8
  - JZ=4'h9
  - HLT=4'hF
  - All other opcodes are execute ops.
- Reset values: state=INIT, loadPC=1, incPC=1, address=0, mem_req=0, mem_addr=0, ir=0, ir_valid=0, halted=0, fetch_err=0, wait counter=0.
- INIT: drive CLR for exactly 1 cycle -> SETTLE.
- SETTLE: HOLD; count PC_LAT cycles -> FETCH.
- FETCH:
  - mem_req=1, mem_addr=pc_addr (registered on FETCH entry, stable while req is high).
  - On mem_ack: ir<=mem_rdata, mem_req<=0 -> DECODE.
  - mem_ack outside FETCH is ignored.
- DECODE (1 cycle):
  - JMP -> UPDATE with LOAD, address=operand.
  - JZ with zero_flag=1 -> UPDATE with LOAD.
  - JZ with zero_flag=0 -> UPDATE with INC.
  - HLT -> HALT.
  - Otherwise -> ISSUE.
- ISSUE:
  - ir_valid=1; ir is stable.
  - When ir_valid&&ir_ready: ir_valid<=0 -> UPDATE with INC.
  - ir_ready while not valid has no effect.
- UPDATE: drive the chosen command (LOAD or INC) for exactly 1 cycle -> SETTLE.
- HALT: HOLD forever; halted=1. Exit only by reset.
- Throughput: minimum 1+PC_LAT+1+1+1 cycles per instruction at zero-latency ack.
- Wrap-around: INC at pc=12'hFFF yields 12'h000 (PC behaviour); the sequencer continues normally.
- Mid-operation reset:
  - All state returns to reset values immediately, including dropping mem_req and ir_valid.
  - After release the sequence restarts from INIT (PC cleared).
- address holds its last value outside LOAD cycles.

Optional Feature:
- Macro FETCH_SEQ_TIMEOUT_EN.
- When defined:
  - A counter increments each FETCH cycle without mem_ack.
  - Reaching TIMEOUT sets fetch_err=1 (sticky until reset), drops mem_req, and enters HALT with halted=1.
  - The counter clears on FETCH entry.
- When undefined:
  - FETCH waits indefinitely.
  - fetch_err is tied to 0 and no counter logic exists.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants OP_JMP, OP_JZ, OP_HLT.
  - PC command constants PC_CLR, PC_LOAD, PC_INC, PC_HOLD (2-bit).
  - State enum.
  - AW/DW defaults.
- No sub-module; a single FSM plus counters. The decode function lives in the package.

Test Plan:
- Reset release, memory returns 16'h1234 at addr 0 with 0-cycle ack -> CLR 1 cycle, mem_req at pc=0, ir_valid with ir=16'h1234, then INC; next fetch at 0x001.
- Word 16'h8ABC at pc 0x001 -> LOAD with address=12'hABC, no ir_valid; next mem_addr=12'hABC.
- JZ 16'h9050: zero_flag=1 -> next fetch 12'h050; zero_flag=0 -> next fetch pc+1.
- ir_ready held low 5 cycles on an ALU op -> ir_valid and ir stable for 5 cycles; PC held (11); INC only after acceptance.
- HLT 16'hF000 -> halted=1, HOLD persists for 50 cycles, mem_req stays 0; rst_n pulse mid-FETCH clears mem_req at once and restarts at addr 0.
- With FETCH_SEQ_TIMEOUT_EN defined and mem_ack never asserted -> fetch_err=1 and halted=1 after 15 FETCH cycles.
